vga_bar_display: RTL and testbench
==================================

# vga_bar_display

Parametrised VGA raster engine for the water-reminder display: generates 640x480-class timing from CLOCK_50 and renders NUM_CH vertical level bars, one per water sensor channel, with low-level alarm blinking. It is the next generation of our single-mode VGA block: geometry, channel count and level resolution are parameters, and level inputs are frame-synchronised to prevent tearing. It sits directly on the board VGA DAC pins and takes levels from the sensor front-end.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (pixel ticks)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (lines)
- CLK_DIV, 2, CLOCK_50 cycles per pixel tick (even, >=2)
- NUM_CH, 4, bar channels (H_ACTIVE divisible by NUM_CH)
- LEVEL_W, 4, bits per channel level
- LOW_THRESH, 3, levels strictly below this are "low"
- BLINK_FRAMES, 30, frames per blink half-period
- MARGIN, 8, blank pixels each side of a bar inside its column

- CLOCK_50  in  1  system clock; everything runs on it
- reset_n  in  1  asynchronous, active-low reset
- levels  in  NUM_CH*LEVEL_W  channel c at bits [c*LEVEL_W +: LEVEL_W], asynchronous to frame
- theme  in  2  palette select
- VGA_CLK  out  1  pixel clock, CLOCK_50/CLK_DIV, 50% duty
- VGA_HS, VGA_VS  out  1  syncs, active-low
- VGA_SYNC_N  out  1  tied 0
- VGA_BLANK_N  out  1  high in active area
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
- frame_start  out  1  one CLOCK_50-cycle pulse at the tick where hcnt=0,vcnt=0
- any_low  out  1  registered OR of per-channel low flags (latched copy)

## Operation
- Tick divider: counts 0..CLK_DIV-1; tick when it wraps; VGA_CLK toggles at half-count so rising edge sits mid-pixel.
- hcnt 0..H_TOTAL-1, vcnt 0..V_TOTAL-1 (TOTAL = sum of four fields); hcnt wraps -> vcnt increments; vcnt wraps at V_TOTAL. Advance only on tick.
- Column tracking incremental, no divider: col index and in-column x reset at hcnt=0, x wraps at H_ACTIVE/NUM_CH, col increments on wrap.
- Level latch: at tick where vcnt==V_ACTIVE, hcnt==0, copy levels into shadow register; bars use shadow only. any_low updated at same instant.
- Blink: frame counter increments at frame_start; at BLINK_FRAMES-1 wraps and toggles blink phase.
- Pixel rule (active area): in bar if MARGIN <= x < colw-MARGIN and vcnt >= V_ACTIVE - level*STEP, STEP = V_ACTIVE >> LEVEL_W (30 default). Level 0 draws nothing; max level draws (2^LEVEL_W-1)*STEP rows.
- Colour: bar normal = blue 0x0040FF (theme 0), green 0x00C040 (1), cyan 0x00C0C0 (2), white 0xFFFFFF (3). Low bar = red 0xFF0000 when blink phase 1, background when 0. Background black; outside active area RGB forced 0.

## Timing
- Pipeline: stage 0 counters, stage 1 geometry/compare, stage 2 registered outputs. HS, VS, BLANK_N and RGB all delayed identically: outputs describe counter state 2 ticks earlier.
- HS low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); VS low for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Reset values: counters, divider, blink counter/phase, shadow levels 0; VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0, VGA_CLK=0, frame_start=0, any_low=0.
- Reset mid-frame: all state returns to reset values immediately; first frame_start 2 ticks after release at position (0,0).
- levels changing at the latch instant: value sampled on that CLOCK_50 edge wins; levels are not synchronised beyond that single register (front-end supplies stable data).

## Configuration
- VGA_BAR_GRID_EN defined: in active area, rows with (V_ACTIVE-1-vcnt) mod STEP == 0 outside bars draw grey 0x404040 (row counter incremental, no modulo). Bars paint over grid.
- Undefined: no grid; background pure black. Timing identical either way.

## Test plan
- Reset asserted mid-line -> all outputs at reset values same cycle; after release HS period 800 ticks = 1600 CLOCK_50 cycles, frame 525 lines.
- Measure HS: low 96 ticks starting 656 ticks after BLANK_N rises; VS low exactly 2 lines; BLANK_N high 640 ticks per line on 480 lines.
- levels=0xF3A0 (ch0=0, ch1=10, ch2=3, ch3=15), theme 0 -> ch1 blue from row 180, ch3 blue from row 30, ch0 no bar, x=0..7 of each column black.
- Change levels mid-active-frame -> display unchanged until next latch at vcnt=480; any_low updates only then.
- ch2 level=2 -> ch2 rows 420..479 red for 30 frames, black for 30 frames; any_low=1.
- With VGA_BAR_GRID_EN -> grey at row 449 in margin pixels, blue inside a level-15 bar at row 449.

Source files
------------

// File: rtl/vga_bar_display.sv
// vga_bar_display: parametrised VGA raster engine for the water-reminder
// display. Generates sync/blank timing from CLOCK_50 and renders NUM_CH
// vertical level bars with a blinking low-level alarm.
// Optional build macro: VGA_BAR_GRID_EN draws a grey horizontal grid (one
// row per level step) behind the bars; timing is identical either way.
module vga_bar_display #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int CLK_DIV      = 2,
    parameter int NUM_CH       = 4,
    parameter int LEVEL_W      = 4,
    parameter int LOW_THRESH   = 3,
    parameter int BLINK_FRAMES = 30,
    parameter int MARGIN       = 8
) (
    input  logic                        CLOCK_50,
    input  logic                        reset_n,
    input  logic [NUM_CH*LEVEL_W-1:0]   levels,
    input  logic [1:0]                  theme,
    output logic                        VGA_CLK,
    output logic                        VGA_HS,
    output logic                        VGA_VS,
    output logic                        VGA_SYNC_N,
    output logic                        VGA_BLANK_N,
    output logic [7:0]                  VGA_R,
    output logic [7:0]                  VGA_G,
    output logic [7:0]                  VGA_B,
    output logic                        frame_start,
    output logic                        any_low
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int COL_W   = H_ACTIVE / NUM_CH;
    localparam int STEP    = V_ACTIVE >> LEVEL_W;

    localparam int DW = $clog2(CLK_DIV);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int XW = $clog2(COL_W + 1);
    localparam int CW = $clog2(NUM_CH + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    localparam logic [DW-1:0]    DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]    DIV_HALF   = DW'(CLK_DIV / 2 - 1);
    localparam logic [HW-1:0]    H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]    H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0]    HS_BEG     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]    HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]    V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]    V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0]    VS_BEG     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]    VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0]    STEP_V     = VW'(STEP);
    localparam logic [XW-1:0]    X_LAST     = XW'(COL_W - 1);
    localparam logic [XW-1:0]    X_LO       = XW'(MARGIN);
    localparam logic [XW-1:0]    X_HI       = XW'(COL_W - MARGIN);
    localparam logic [CW-1:0]    COL_END    = CW'(NUM_CH);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [LEVEL_W:0] LOW_V      = (LEVEL_W + 1)'(LOW_THRESH);

    logic [DW-1:0]      div_cnt;
    logic               tick;
    logic [HW-1:0]      hcnt;
    logic [VW-1:0]      vcnt;
    logic [XW-1:0]      x;
    logic [CW-1:0]      col;
    logic [LEVEL_W-1:0] shadow [NUM_CH];
    logic [BW-1:0]      blink_cnt;
    logic               blink_phase;
    logic               low_in;
    logic [LEVEL_W-1:0] cur_level;
    logic [VW-1:0]      bar_top;
    logic               active;
    logic               in_bar;
    logic               cur_low;
    logic [23:0]        bar_rgb;
    logic [23:0]        bg_rgb;
    logic [23:0]        pix_rgb;
    logic               grid_row;
    logic               s1_hs;
    logic               s1_vs;
    logic               s1_blank_n;
    logic [23:0]        s1_rgb;

    assign tick       = (div_cnt == DIV_LAST);
    assign VGA_SYNC_N = 1'b0;

    // Pixel tick divider; VGA_CLK rises at half-count so its edge is mid-pixel.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            VGA_CLK <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (div_cnt == DIV_HALF)
                VGA_CLK <= 1'b1;
            else if (tick)
                VGA_CLK <= 1'b0;
        end
    end

    // Stage 0: raster counters plus incremental column index / in-column x.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= '0;
            vcnt <= '0;
            x    <= '0;
            col  <= '0;
        end else if (tick) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
                x    <= '0;
                col  <= '0;
            end else begin
                hcnt <= hcnt + 1'b1;
                if (x == X_LAST) begin
                    x <= '0;
                    // col parks at NUM_CH through horizontal blanking
                    if (col != COL_END)
                        col <= col + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    // Low-level flag over the live inputs, captured only at the latch instant.
    always_comb begin
        low_in = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++)
            low_in |= ({1'b0, levels[c*LEVEL_W +: LEVEL_W]} < LOW_V);
    end

    // Frame-synchronous level shadow and any_low, updated at first blank line.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++)
                shadow[c] <= '0;
            any_low <= 1'b0;
        end else if (tick && vcnt == V_ACT && hcnt == '0) begin
            for (int unsigned c = 0; c < NUM_CH; c++)
                shadow[c] <= levels[c*LEVEL_W +: LEVEL_W];
            any_low <= low_in;
        end
    end

    // Frame-start pulse and blink phase, stepping once per frame.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            frame_start <= tick && hcnt == '0 && vcnt == '0;
            if (tick && hcnt == '0 && vcnt == '0) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

`ifdef VGA_BAR_GRID_EN
    localparam int GW = $clog2(STEP + 1);
    localparam logic [GW-1:0] GRID_INIT = GW'((V_ACTIVE - 1) % STEP);
    localparam logic [GW-1:0] GRID_TOP  = GW'(STEP - 1);

    logic [GW-1:0] grid_cnt;

    // Counts (V_ACTIVE-1-vcnt) mod STEP downwards, one step per line.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            grid_cnt <= GRID_INIT;
        else if (tick && hcnt == H_LAST) begin
            if (vcnt == V_LAST)
                grid_cnt <= GRID_INIT;
            else
                grid_cnt <= (grid_cnt == '0) ? GRID_TOP : grid_cnt - 1'b1;
        end
    end

    assign grid_row = (grid_cnt == '0);
`else
    assign grid_row = 1'b0;
`endif

    // Stage 1 geometry: bar extent of the current column and pixel colour.
    always_comb begin
        cur_level = '0;
        for (int unsigned c = 0; c < NUM_CH; c++)
            if (col == CW'(c))
                cur_level = shadow[c];
        bar_top = V_ACT - VW'(cur_level) * STEP_V;
        active  = (hcnt < H_ACT) && (vcnt < V_ACT);
        in_bar  = active && (col != COL_END) && (x >= X_LO) && (x < X_HI) &&
                  (cur_level != '0) && (vcnt >= bar_top);
        cur_low = ({1'b0, cur_level} < LOW_V);
        case (theme)
            2'd0:    bar_rgb = 24'h0040FF;
            2'd1:    bar_rgb = 24'h00C040;
            2'd2:    bar_rgb = 24'h00C0C0;
            default: bar_rgb = 24'hFFFFFF;
        endcase
        bg_rgb  = grid_row ? 24'h404040 : 24'h000000;
        pix_rgb = '0;
        if (in_bar) begin
            if (cur_low)
                pix_rgb = blink_phase ? 24'hFF0000 : bg_rgb;
            else
                pix_rgb = bar_rgb;
        end else if (active) begin
            pix_rgb = bg_rgb;
        end
    end

    // Stage 1 register: syncs, blank and colour for the counter state.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            s1_hs      <= 1'b1;
            s1_vs      <= 1'b1;
            s1_blank_n <= 1'b0;
            s1_rgb     <= '0;
        end else if (tick) begin
            s1_hs      <= !((hcnt >= HS_BEG) && (hcnt < HS_END));
            s1_vs      <= !((vcnt >= VS_BEG) && (vcnt < VS_END));
            s1_blank_n <= active;
            s1_rgb     <= pix_rgb;
        end
    end

    // Stage 2 register: all DAC-facing outputs share the same two-tick delay.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (tick) begin
            VGA_HS      <= s1_hs;
            VGA_VS      <= s1_vs;
            VGA_BLANK_N <= s1_blank_n;
            VGA_R       <= s1_rgb[23:16];
            VGA_G       <= s1_rgb[15:8];
            VGA_B       <= s1_rgb[7:0];
        end
    end

endmodule

// File: tb/tb_vga_bar_display.sv
// Scoreboard bench for vga_bar_display on a reduced raster (40x38 total,
// 32x32 active, 4 columns of 8 pixels, STEP 2, blink every 2 frames).
module tb_vga_bar_display;

    localparam int HA = 32, HFP = 2, HSW = 4, HBP = 2;
    localparam int VA = 32, VFP = 2, VSW = 2, VBP = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FR = HT * VT;

    localparam logic [23:0] BLK   = 24'h000000;
    localparam logic [23:0] BLUE  = 24'h0040FF;
    localparam logic [23:0] GREEN = 24'h00C040;
    localparam logic [23:0] CYAN  = 24'h00C0C0;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] RED   = 24'hFF0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] levels = '0;
    logic [1:0]  theme = '0;
    logic        vga_clk, hs, vs, sync_n, blank_n, frame_start, any_low;
    logic [7:0]  r, g, b;

    typedef struct {
        int          p;
        logic [23:0] rgb;
        logic        al;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   nprint = 0;
    int   cyc;

    vga_bar_display #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CLK_DIV(2), .NUM_CH(4), .LEVEL_W(4), .LOW_THRESH(3),
        .BLINK_FRAMES(2), .MARGIN(2)
    ) dut (
        .CLOCK_50(clk), .reset_n(rst_n), .levels(levels), .theme(theme),
        .VGA_CLK(vga_clk), .VGA_HS(hs), .VGA_VS(vs), .VGA_SYNC_N(sync_n),
        .VGA_BLANK_N(blank_n), .VGA_R(r), .VGA_G(g), .VGA_B(b),
        .frame_start(frame_start), .any_low(any_low)
    );

    always #5 clk = ~clk;

    // CLOCK_50 edges since the last reset release.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (nprint < 40) $display("FAIL %s: got %h expected %h", name, act, exp);
            nprint++;
        end
    endtask

    task automatic push(input int f, input int h, input int v, input logic [23:0] rgb,
                        input logic al, input string nm);
        exp_t e;
        int   i;
        e.p = f * FR + v * HT + h;
        e.rgb = rgb;
        e.al = al;
        e.name = $sformatf("%s(f%0d,x%0d,y%0d)", nm, f, h, v);
        i = 0;
        while (i < sb.size() && sb[i].p <= e.p) i++;
        sb.insert(i, e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: sync/clock timing every cycle, scoreboard pops per pixel.
    always @(negedge clk) begin : mon
        int   k, p, h, v;
        logic exp_bl, exp_fs;
        exp_t e;
        if (rst_n) begin
            check("vga_clk", vga_clk, cyc % 2);
            exp_fs = (cyc >= 2) && ((cyc - 2) % (2 * FR) == 0);
            if (frame_start || exp_fs) check($sformatf("frame_start@%0d", cyc), frame_start, exp_fs);
            if (cyc % 2 == 1) begin
                k = (cyc - 1) / 2;
                if (k < 2) begin
                    check("startup_outputs", {hs, vs, blank_n, r, g, b}, {3'b110, 24'h0});
                end else begin
                    p = k - 2;
                    h = p % HT;
                    v = (p / HT) % VT;
                    exp_bl = (h < HA) && (v < VA);
                    check($sformatf("sync_blank(x%0d,y%0d)", h, v), {hs, vs, blank_n},
                          {!(h >= HA + HFP && h < HA + HFP + HSW),
                           !(v >= VA + VFP && v < VA + VFP + VSW), exp_bl});
                    if (!exp_bl) check($sformatf("blank_rgb(x%0d,y%0d)", h, v), {r, g, b}, 0);
                    while (sb.size() > 0 && sb[0].p < p) begin
                        e = sb.pop_front();
                        check({"missed_", e.name}, 0, 1);
                    end
                    if (sb.size() > 0 && sb[0].p == p) begin
                        e = sb.pop_front();
                        check({"rgb_", e.name}, {r, g, b}, e.rgb);
                        check({"any_low_", e.name}, any_low, e.al);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_sync_blank", {hs, vs, blank_n}, 3'b110);
        check("reset_rgb", {r, g, b}, 0);
        check("reset_clk_fs_low", {vga_clk, frame_start, any_low}, 0);
        check("sync_n_tied", sync_n, 0);

        push(0, 10, 12, BLK, 0, "f0_shadow_zero");
        push(0, 26, 2, BLK, 0, "f0_shadow_zero");
        push(0, 31, 31, BLK, 0, "f0_any_low_before_latch");
        push(0, 0, 32, BLK, 1, "f0_any_low_after_latch");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Frame 1: levels 0xF3A0 (ch0=0, ch1=10, ch2=3, ch3=15), theme 0
        wait_cyc(600);
        levels = 16'hF3A0;
        theme = 2'd0;
        push(1, 10, 12, BLUE, 1, "ch1_top_row");
        push(1, 10, 11, BLK, 1, "ch1_above_top");
        push(1, 9, 20, BLK, 1, "ch1_left_margin");
        push(1, 14, 20, BLK, 1, "ch1_right_margin");
        push(1, 13, 31, BLUE, 1, "ch1_bottom");
        push(1, 26, 2, BLUE, 1, "ch3_full_top");
        push(1, 26, 1, BLK, 1, "ch3_above_full");
        push(1, 29, 31, BLUE, 1, "ch3_last_x");
        push(1, 30, 31, BLK, 1, "ch3_margin");
        push(1, 3, 31, BLK, 1, "ch0_level0");
        push(1, 18, 26, BLUE, 1, "ch2_level3_top");
        push(1, 18, 25, BLK, 1, "ch2_above");
        push(1, 3, 25, BLK, 1, "hold_after_mid_change");
        push(1, 31, 31, BLK, 1, "any_low_hold");
        push(1, 0, 32, BLK, 0, "any_low_update");

        // Mid-frame change: 0xF5A5 applies from frame 2 only
        wait_cyc(2 * (FR + 600));
        levels = 16'hF5A5;
        wait_cyc(2 * (FR + 1400));
        theme = 2'd1;
        push(2, 3, 25, GREEN, 0, "ch0_l5_green");
        push(2, 3, 21, BLK, 0, "ch0_l5_above");
        push(2, 2, 22, GREEN, 0, "ch0_first_x");
        push(2, 1, 22, BLK, 0, "ch0_margin");
        push(2, 5, 31, GREEN, 0, "ch0_last_x");
        push(2, 6, 31, BLK, 0, "ch0_right_margin");
        push(2, 18, 22, GREEN, 0, "ch2_l5_top");

        // 0xF2A5: ch2 low (level 2) from frame 3; blink off frames 3-4, on frame 5
        wait_cyc(2 * (2 * FR + 600));
        levels = 16'hF2A5;
        push(2, 0, 32, BLK, 1, "any_low_set");
        wait_cyc(2 * (2 * FR + 1400));
        theme = 2'd2;
        push(3, 18, 28, BLK, 1, "blink_off_top");
        push(3, 21, 31, BLK, 1, "blink_off_bottom");
        push(3, 10, 12, CYAN, 1, "ch1_cyan");
        push(3, 3, 25, CYAN, 1, "ch0_cyan");
        push(4, 18, 28, BLK, 1, "blink_off_f4");
        wait_cyc(2 * (4 * FR + 1400));
        theme = 2'd3;
        push(5, 18, 28, RED, 1, "blink_on_top");
        push(5, 21, 31, RED, 1, "blink_on_bottom");
        push(5, 18, 27, BLK, 1, "blink_above_bar");
        push(5, 17, 30, BLK, 1, "blink_left_margin");
        push(5, 22, 30, BLK, 1, "blink_right_margin");
        push(5, 10, 12, WHITE, 1, "ch1_white");

        // Reset mid-line in frame 6
        wait_cyc(2 * (6 * FR + 500));
        check("sb_drained_before_reset", sb.size(), 0);
        sb.delete();
        check("pre_reset_any_low", any_low, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_sync_blank", {hs, vs, blank_n}, 3'b110);
        check("midrst_rgb", {r, g, b}, 0);
        check("midrst_clk_fs_low", {vga_clk, frame_start, any_low}, 0);
        push(0, 10, 12, BLK, 0, "rst_shadow_clear");
        push(0, 31, 31, BLK, 0, "rst_any_low_clear");
        push(0, 0, 32, BLK, 1, "rst_any_low_relatch");
        push(1, 18, 28, RED, 1, "rst_blink_restart");
        push(1, 10, 12, WHITE, 1, "rst_ch1_white");
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;

        wait_cyc(2 * (FR + 1300));
        check("sb_empty_at_end", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
